// File: rtl/dualmem_line_reader_pkg.sv
// Shared types and constants for the dual-port memory line reader.
// The memory is organised as 512-bit lines with one enable per 32-bit lane.
package dualmem_line_reader_pkg;

   localparam int LINE_W   = 512;
   localparam int MEM_EN_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DRAIN   = 2'd3
   } state_e;

endpackage : dualmem_line_reader_pkg

// File: rtl/dualmem_line_reader.sv
// Reads a run of consecutive 512-bit lines from port B of a dual-port memory
// and serialises each line into an AXI-Stream-like beat stream, LSBs first.
// Each line costs one issue cycle, one capture cycle and 512/OUT_W drain beats.
module dualmem_line_reader
   import dualmem_line_reader_pkg::*;
#(
   parameter int OUT_W  = 64,   // 32, 64 or 128
   parameter int ADDR_W = 9
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [ADDR_W-1:0]     base_addr_i,
   input  logic [ADDR_W:0]       num_lines_i,
   input  logic                  abort_i,
   output logic [MEM_EN_W-1:0]   mem_en_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   input  logic [LINE_W-1:0]     mem_rdata_i,
   output logic                  tvalid_o,
   input  logic                  tready_i,
   output logic [OUT_W-1:0]      tdata_o,
   output logic                  tlast_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int BEATS = LINE_W / OUT_W;
   localparam int IDX_W = $clog2(BEATS);

   localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(BEATS - 1);
   localparam logic [IDX_W-1:0]  PRELAST_IDX = IDX_W'(BEATS - 2);
   localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
   localparam logic [ADDR_W:0]   ONE_LINE    = (ADDR_W + 1)'(1);

   // A requested count of zero still moves one line.
   function automatic logic [ADDR_W:0] norm_count(input logic [ADDR_W:0] n);
      return (n == '0) ? ONE_LINE : n;
   endfunction

   state_e                  r_state;
   logic                    r_busy;
   logic                    r_mem_en;
   logic                    r_tvalid;
   logic                    r_tlast;
   logic [ADDR_W-1:0]       r_addr;
   logic [ADDR_W:0]         r_rem;
   logic [IDX_W-1:0]        r_idx;
   logic [LINE_W-1:0]       r_line_buf;

   logic                    w_accept;
   logic [BEATS-1:0][OUT_W-1:0] w_beats;

   // A beat moves only while the FSM is draining and the sink is ready.
   assign w_accept = r_tvalid & tready_i;

   // Beat 0 occupies the least-significant OUT_W bits of the line.
   assign w_beats  = r_line_buf;

   // Control FSM: owns state, counters and all registered handshake outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_mem_en <= 1'b0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_addr   <= '0;
         r_rem    <= '0;
         r_idx    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // start wins over a simultaneous abort here
               if (start_i) begin
                  r_state  <= ST_ISSUE;
                  r_busy   <= 1'b1;
                  r_mem_en <= 1'b1;
                  r_addr   <= base_addr_i;
                  r_rem    <= norm_count(num_lines_i);
               end
            end

            ST_ISSUE: begin
               r_mem_en <= 1'b0;
               if (abort_i) begin
                  // the read already on the port is simply never captured
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_CAPTURE;
               end
            end

            ST_CAPTURE: begin
               if (abort_i) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state  <= ST_DRAIN;
                  r_tvalid <= 1'b1;
                  r_tlast  <= 1'b0;
                  r_idx    <= '0;
               end
            end

            ST_DRAIN: begin
               if (abort_i) begin
                  r_state  <= ST_IDLE;
                  r_busy   <= 1'b0;
                  r_tvalid <= 1'b0;
                  r_tlast  <= 1'b0;
               end else if (w_accept) begin
                  if (r_idx == LAST_IDX) begin
                     // line finished: step to the next line, wrapping the address
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     r_rem    <= r_rem - ONE_LINE;
                     r_addr   <= r_addr + ADDR_ONE;
                     if (r_rem > ONE_LINE) begin
                        r_state  <= ST_ISSUE;
                        r_mem_en <= 1'b1;
                     end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_idx   <= r_idx + IDX_ONE;
                     // flag the next beat if it closes the final line
                     r_tlast <= (r_rem == ONE_LINE) && (r_idx == PRELAST_IDX);
                  end
               end
            end

            default: begin
               r_state  <= ST_IDLE;
               r_busy   <= 1'b0;
               r_mem_en <= 1'b0;
               r_tvalid <= 1'b0;
               r_tlast  <= 1'b0;
            end
         endcase
      end
   end

   // Line buffer: datapath only, captured the cycle after the read is issued.
   always_ff @(posedge clk_i) begin
      if (r_state == ST_CAPTURE) begin
         r_line_buf <= mem_rdata_i;
      end
   end

   assign mem_en_o   = {MEM_EN_W{r_mem_en}};
   assign mem_addr_o = r_addr;
   assign tvalid_o   = r_tvalid;
   assign tdata_o    = w_beats[r_idx];
   assign tlast_o    = r_tlast;
   assign busy_o     = r_busy;
   // completion coincides with acceptance of the very last beat
   assign done_o     = w_accept & r_tlast & ~abort_i;

endmodule : dualmem_line_reader

// File: tb/tb_dualmem_line_reader.sv
// Scoreboard bench for dualmem_line_reader: stimulus queues expected beats and
// line addresses, a negedge monitor pops and compares whatever the DUT shows.
`timescale 1ns/1ps
module tb_dualmem_line_reader;

   localparam int OUT_W  = 64;
   localparam int ADDR_W = 9;
   localparam int BEATS  = 512 / OUT_W;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } beat_t;

   logic               clk       = 1'b0;
   logic               rst_n     = 1'b0;
   logic               start     = 1'b0;
   logic               abort     = 1'b0;
   logic               tready    = 1'b0;
   logic [ADDR_W-1:0]  base      = '0;
   logic [ADDR_W:0]    num       = '0;
   logic [15:0]        mem_en;
   logic [ADDR_W-1:0]  mem_addr;
   logic [511:0]       rdata     = '0;
   logic               tvalid;
   logic [OUT_W-1:0]   tdata;
   logic               tlast;
   logic               busy;
   logic               done;

   logic [511:0]       mem [0:511];

   beat_t              exp_q[$];
   int                 addr_q[$];

   int nchecks  = 0;
   int nerrors  = 0;
   int done_cnt = 0;
   int en_cnt   = 0;
   int acc_cnt  = 0;

   bit                 rand_rdy  = 1'b0;
   bit                 rdy_fixed = 1'b0;
   logic               prev_stall = 1'b0;
   logic [63:0]        prev_data  = '0;
   logic               prev_last  = 1'b0;

   always #5 clk = ~clk;

   dualmem_line_reader #(.OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .base_addr_i (base),
      .num_lines_i (num),
      .abort_i     (abort),
      .mem_en_o    (mem_en),
      .mem_addr_o  (mem_addr),
      .mem_rdata_i (rdata),
      .tvalid_o    (tvalid),
      .tready_i    (tready),
      .tdata_o     (tdata),
      .tlast_o     (tlast),
      .busy_o      (busy),
      .done_o      (done)
   );

   // memory port B model: synchronous read, data valid one cycle after enable
   always @(posedge clk) begin
      if (mem_en != 16'h0000) rdata <= mem[mem_addr];
   end

   // single driver of tready
   always @(posedge clk) begin
      #2;
      tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      nchecks++;
      if (act !== req) begin
         nerrors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [63:0] model_beat(input int line, input int k);
      logic [511:0] l;
      l = mem[line];
      return l[k*64 +: 64];
   endfunction

   task automatic push_line(input int line, input int nbeats, input bit last_line);
      beat_t b;
      addr_q.push_back(line);
      for (int k = 0; k < nbeats; k++) begin
         b.data = model_beat(line, k);
         b.last = last_line && (k == BEATS - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic start_xfer(input int b, input int n);
      @(posedge clk); #1;
      base  = ADDR_W'(b);
      num   = (ADDR_W + 1)'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 64'(busy), 64'(0));
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      beat_t e;
      if (prev_stall && tvalid) begin
         check("stall_data", tdata, prev_data);
         check("stall_last", 64'(tlast), 64'(prev_last));
      end
      if (mem_en != 16'h0000) begin
         en_cnt++;
         check("mem_en_all", 64'(mem_en), 64'(16'hFFFF));
         if (addr_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL mem_addr: got unexpected read of line %0d, required none", mem_addr);
         end else begin
            check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
         end
      end
      if (tvalid && tready) begin
         acc_cnt++;
         if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL beat: got extra beat 0x%0h, required none", tdata);
         end else begin
            e = exp_q.pop_front();
            check("tdata", tdata, e.data);
            check("tlast", 64'(tlast), 64'(e.last));
         end
      end
      if (done) begin
         done_cnt++;
         check("done_with_last", 64'(tvalid && tready && tlast), 64'(1));
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0, a0, cyc, n;
      beat_t hb;
      bit saw_valid, saw_busy;

      for (int i = 0; i < 512; i++)
         for (int j = 0; j < 64; j++)
            mem[i][j*8 +: 8] = 8'(j + i * 5);

      // reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",     64'(busy),     64'(0));
      check("rst_tvalid",   64'(tvalid),   64'(0));
      check("rst_tlast",    64'(tlast),    64'(0));
      check("rst_done",     64'(done),     64'(0));
      check("rst_mem_en",   64'(mem_en),   64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      rst_n     = 1'b1;
      rdy_fixed = 1'b1;
      repeat (2) @(posedge clk);

      // A: one line from address 0, incrementing bytes
      d0 = done_cnt;
      addr_q.push_back(0);
      hb.data = 64'h0706050403020100;
      hb.last = 1'b0;
      exp_q.push_back(hb);
      for (int k = 1; k < BEATS; k++) begin
         for (int b = 0; b < 8; b++) hb.data[b*8 +: 8] = 8'(8 * k + b);
         hb.last = (k == BEATS - 1);
         exp_q.push_back(hb);
      end
      start_xfer(0, 1);
      @(negedge clk);
      check("A_issue_en",     64'(mem_en), 64'(16'hFFFF));
      check("A_issue_tvalid", 64'(tvalid), 64'(0));
      @(negedge clk);
      check("A_capture_tvalid", 64'(tvalid), 64'(0));
      check("A_capture_en",     64'(mem_en), 64'(0));
      @(negedge clk);
      check("A_first_tvalid", 64'(tvalid), 64'(1));
      wait_idle("A_idle", 100);
      check("A_done_cnt", 64'(done_cnt - d0), 64'(1));
      check("A_queue",    64'(exp_q.size()), 64'(0));

      // B: address wrap 510,511,0,1 and full-rate throughput
      d0 = done_cnt;
      a0 = acc_cnt;
      push_line(510, BEATS, 1'b0);
      push_line(511, BEATS, 1'b0);
      push_line(0,   BEATS, 1'b0);
      push_line(1,   BEATS, 1'b1);
      start_xfer(510, 4);
      cyc = 0;
      while (busy && cyc < 200) begin
         @(negedge clk);
         if (busy) cyc++;
      end
      check("B_busy_cycles", 64'(cyc), 64'(40));
      check("B_beats",       64'(acc_cnt - a0), 64'(32));
      check("B_done_cnt",    64'(done_cnt - d0), 64'(1));
      check("B_addr_queue",  64'(addr_q.size()), 64'(0));
      check("B_queue",       64'(exp_q.size()), 64'(0));

      // C: random backpressure over three lines
      d0 = done_cnt;
      rand_rdy = 1'b1;
      push_line(100, BEATS, 1'b0);
      push_line(101, BEATS, 1'b0);
      push_line(102, BEATS, 1'b1);
      start_xfer(100, 3);
      wait_idle("C_idle", 1000);
      rand_rdy = 1'b0;
      repeat (2) @(posedge clk);
      check("C_done_cnt", 64'(done_cnt - d0), 64'(1));
      check("C_queue",    64'(exp_q.size()), 64'(0));

      // D: abort on beat 3 of line 1, then a fresh start
      d0 = done_cnt;
      e0 = en_cnt;
      a0 = acc_cnt;
      push_line(200, BEATS, 1'b0);
      push_line(201, 3, 1'b0);
      start_xfer(200, 5);
      n = 0;
      while ((acc_cnt - a0) < 11 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("D_reach_beat", 64'(acc_cnt - a0), 64'(11));
      rdy_fixed = 1'b0;
      abort     = 1'b1;
      @(posedge clk); #1;
      abort     = 1'b0;
      rdy_fixed = 1'b1;
      check("D_abort_busy",   64'(busy),   64'(0));
      check("D_abort_tvalid", 64'(tvalid), 64'(0));
      repeat (20) @(posedge clk);
      #1;
      check("D_en_cnt",   64'(en_cnt - e0),   64'(2));
      check("D_done_cnt", 64'(done_cnt - d0), 64'(0));
      check("D_queue",    64'(exp_q.size()),  64'(0));
      d0 = done_cnt;
      push_line(5, BEATS, 1'b1);
      start_xfer(5, 1);
      wait_idle("D_restart_idle", 100);
      check("D_restart_done", 64'(done_cnt - d0), 64'(1));
      check("D_restart_queue", 64'(exp_q.size()), 64'(0));

      // E: count 0 moves one line; start while busy is ignored
      d0 = done_cnt;
      e0 = en_cnt;
      a0 = acc_cnt;
      push_line(7, BEATS, 1'b1);
      start_xfer(7, 0);
      repeat (3) @(posedge clk);
      #1;
      base  = ADDR_W'(300);
      num   = (ADDR_W + 1)'(2);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("E_idle", 100);
      repeat (15) @(posedge clk);
      #1;
      check("E_beats",    64'(acc_cnt - a0),  64'(8));
      check("E_en_cnt",   64'(en_cnt - e0),   64'(1));
      check("E_done_cnt", 64'(done_cnt - d0), 64'(1));
      check("E_busy",     64'(busy),          64'(0));

      // F: reset asserted mid-drain
      push_line(50, BEATS, 1'b0);
      start_xfer(50, 2);
      n = 0;
      while (!tvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("F_reach_drain", 64'(tvalid), 64'(1));
      @(negedge clk);
      d0 = done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      check("F_rst_tvalid",   64'(tvalid),   64'(0));
      check("F_rst_busy",     64'(busy),     64'(0));
      check("F_rst_tlast",    64'(tlast),    64'(0));
      check("F_rst_done",     64'(done),     64'(0));
      check("F_rst_mem_en",   64'(mem_en),   64'(0));
      check("F_rst_mem_addr", 64'(mem_addr), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      addr_q.delete();
      rst_n = 1'b1;
      saw_valid = 1'b0;
      saw_busy  = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (tvalid) saw_valid = 1'b1;
         if (busy)   saw_busy  = 1'b1;
      end
      check("F_post_tvalid", 64'(saw_valid), 64'(0));
      check("F_post_busy",   64'(saw_busy),  64'(0));
      check("F_post_done",   64'(done_cnt - d0), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule : tb_dualmem_line_reader
